// File: rtl/game_fnd.sv
// game_fnd: three-reel slot machine FND driver with jackpot freeze-and-blink.
module game_fnd #(
  parameter int P_TICK_DIV   = 25_000_000,
  parameter int P_HOLD_TICKS = 6
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic [6:0] o_FND0,
  output logic [6:0] o_FND1,
  output logic [6:0] o_FND2
);
  localparam int CW = P_TICK_DIV > 1 ? $clog2(P_TICK_DIV) : 1;
  localparam int HW = P_HOLD_TICKS > 1 ? $clog2(P_HOLD_TICKS) : 1;
  typedef enum logic {RUN, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [HW-1:0] h;
  logic [3:0] d0, d1, d2, n0, n1, n2;
  logic ph1;
  logic [1:0] ph2;
  logic tick, jackpot, hold_done, blank;

  function automatic logic [3:0] inc(input logic [3:0] d);
    return d == 4'd9 ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  // Jackpot is judged on the reel values this tick would produce
  always_comb begin
    tick      = cnt == CW'(P_TICK_DIV - 1);
    n0        = inc(d0);
    n1        = ph1 ? inc(d1) : d1;
    n2        = ph2 == 2'd2 ? inc(d2) : d2;
    jackpot   = n0 == n1 && n1 == n2 && n0 != 4'd0;
    hold_done = h == HW'(P_HOLD_TICKS - 1);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) state <= RUN;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (tick) state_nx = state == RUN ? (jackpot ? HOLD : RUN) : (hold_done ? RUN : HOLD);
  end

  always_comb begin
    blank  = state == HOLD && h[0];
    o_FND0 = blank ? 7'h7F : seg(d0);
    o_FND1 = blank ? 7'h7F : seg(d1);
    o_FND2 = blank ? 7'h7F : seg(d2);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      cnt <= '0;
      h   <= '0;
      d0  <= '0;
      d1  <= '0;
      d2  <= '0;
      ph1 <= 1'b0;
      ph2 <= 2'd0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) h <= (state == HOLD && !hold_done) ? h + HW'(1) : '0;
      if (tick && state == RUN) begin
        d0  <= n0;
        d1  <= n1;
        d2  <= n2;
        ph1 <= ~ph1;
        ph2 <= ph2 == 2'd2 ? 2'd0 : ph2 + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_game_fnd.sv
// tb_game_fnd: scoreboard bench running two game_fnd instances against a tick-count reference model.
module tb_game_fnd;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] fa0, fa1, fa2, fb0, fb1, fb2;
  int checks = 0;
  int errors = 0;

  typedef struct {logic [6:0] a0, a1, a2, b0, b1, b2;} exp_t;
  exp_t sb[$];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int div [2] = '{1, 5};
  int hold [2] = '{4, 2};
  int m_cnt [2];
  int m_t [2];
  int m_h [2];
  bit m_hd [2];

  game_fnd #(.P_TICK_DIV(1), .P_HOLD_TICKS(4)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .o_FND0(fa0), .o_FND1(fa1), .o_FND2(fa2));
  game_fnd #(.P_TICK_DIV(5), .P_HOLD_TICKS(2)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .o_FND0(fb0), .o_FND1(fb1), .o_FND2(fb2));

  always #5 clk = ~clk;

  // Reels are a pure function of run ticks t since reset: t, t/2, t/3 mod 10
  task automatic model_step(input int k, input logic r);
    int a, b, c;
    if (!r) begin
      m_cnt[k] = 0; m_t[k] = 0; m_h[k] = 0; m_hd[k] = 0;
    end else if (m_cnt[k] == div[k] - 1) begin
      m_cnt[k] = 0;
      if (m_hd[k]) begin
        if (m_h[k] == hold[k] - 1) begin m_hd[k] = 0; m_h[k] = 0; end
        else m_h[k]++;
      end else begin
        m_t[k]++;
        a = m_t[k] % 10; b = (m_t[k] / 2) % 10; c = (m_t[k] / 3) % 10;
        if (a == b && b == c && a != 0) begin m_hd[k] = 1; m_h[k] = 0; end
      end
    end else m_cnt[k]++;
  endtask

  function automatic logic [6:0] m_out(input int k, input int div_by);
    if (m_hd[k] && m_h[k] % 2 == 1) return 7'h7F;
    return seg_tab[(m_t[k] / div_by) % 10];
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic cyc(input logic r);
    exp_t e;
    rst = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, r);
    e.a0 = m_out(0, 1); e.a1 = m_out(0, 2); e.a2 = m_out(0, 3);
    e.b0 = m_out(1, 1); e.b1 = m_out(1, 2); e.b2 = m_out(1, 3);
    sb.push_back(e);
    @(negedge clk);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a_fnd0", fa0, e.a0); chk("a_fnd1", fa1, e.a1); chk("a_fnd2", fa2, e.a2);
      chk("b_fnd0", fb0, e.b0); chk("b_fnd1", fb1, e.b1); chk("b_fnd2", fb2, e.b2);
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    cyc(1'b0);
    cyc(1'b0);
    chk("reset_a0", fa0, 7'h40);
    chk("reset_b2", fb2, 7'h40);
    for (int i = 0; i < 6; i++) cyc(1'b1);
    chk("rate6_a0", fa0, 7'h02);
    chk("rate6_a1", fa1, 7'h30);
    chk("rate6_a2", fa2, 7'h24);
    for (int i = 0; i < 53; i++) cyc(1'b1);
    chk("jackpot_a0", fa0, 7'h10);
    chk("jackpot_a2", fa2, 7'h10);
    cyc(1'b1);
    chk("hold_blank", fa1, 7'h7F);
    for (int i = 0; i < 70; i++) cyc(1'b1);
    n = 0;
    while (!(m_hd[0] && m_h[0] % 2 == 1) && n < 200) begin
      cyc(1'b1);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL hold_wait: observed %0d cycles expected < 200", n);
    end
    chk("mid_hold_blank", fa0, 7'h7F);
    cyc(1'b0);
    chk("mid_hold_reset", fa0, 7'h40);
    for (int i = 0; i < 40; i++) cyc(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
